// File: rtl/core_pkg.sv
// core_pkg: shared widths, fetch packet type and reset PC for the core
package core_pkg;
  localparam int XLEN = 32;
  localparam int ILEN = 32;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_pkt_t;
endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: imem, redirect and decode handshake signals of the fetch stage
interface fetch_stage_if;
  import core_pkg::*;
  logic [XLEN-1:0] imem_addr;
  logic [ILEN-1:0] imem_instr;
  logic redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic out_valid;
  logic out_ready;
  logic [XLEN-1:0] out_pc;
  logic [ILEN-1:0] out_instr;
  modport master (
    output imem_addr, out_valid, out_pc, out_instr,
    input imem_instr, redirect_valid, redirect_pc, out_ready
  );
  modport slave (
    input imem_addr, out_valid, out_pc, out_instr,
    output imem_instr, redirect_valid, redirect_pc, out_ready
  );
endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO of fetch packets; flush beats push
module fetch_fifo import core_pkg::*; #(
  parameter int DEPTH = 2,
  parameter type T = fetch_pkt_t
) (
  input logic clk,
  input logic rst,
  input logic push,
  input logic pop,
  input logic flush,
  input T din,
  output logic full,
  output logic empty,
  output T head
);
  localparam int AW = $clog2(DEPTH);
  T mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0] count;
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  always_ff @(posedge clk)
    if (push && !flush && !rst) mem[wr_ptr] <= din;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign head = mem[rd_ptr];
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC register, imem fetch and fetch buffer feeding decode
module fetch_stage import core_pkg::*; #(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int FIFO_DEPTH = 2
) (
  input logic clk,
  input logic rst,
  fetch_stage_if.master bus
);
  logic [XLEN-1:0] pc;
  logic full, empty, push, pop;
  fetch_pkt_t head;
  assign pop = !empty && bus.out_ready;
  // a full buffer still accepts a fetch when its head leaves in the same cycle
  assign push = !bus.redirect_valid && (!full || pop);
  always_ff @(posedge clk)
    pc <= rst ? RESET_PC
        : bus.redirect_valid ? {bus.redirect_pc[XLEN-1:2], 2'b00}
        : push ? pc + 32'd4 : pc;
  fetch_fifo #(.DEPTH(FIFO_DEPTH), .T(fetch_pkt_t)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .pop(pop),
    .flush(bus.redirect_valid),
    .din('{pc: pc, instr: bus.imem_instr}),
    .full(full),
    .empty(empty),
    .head(head)
  );
  assign bus.imem_addr = pc;
  assign bus.out_valid = !empty;
  assign bus.out_pc = head.pc;
  assign bus.out_instr = head.instr;
endmodule
